// File: rtl/dma_hold_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dma_hold_arbiter
//
// Shares the 8088 local bus between NREQ bus-master requesters and the CPU
// using the minimum-mode HOLD/HLDA handshake. A request raises HOLD. Once the
// CPU acknowledges with HLDA, exactly one requester is granted the bus in
// round-robin order. Each tenure is bounded by MAX_HOLD_CYCLES. Every tenure
// ends by releasing HOLD, so the CPU always regains the bus between tenures.
//
// Parameters
//   NREQ            number of requesters (2..8)
//   MAX_HOLD_CYCLES longest single tenure, in cycles of GNT high (>=2)
//
// Ports
//   CLK       in   system clock, all state changes on posedge
//   RESET_N   in   asynchronous active-low reset
//   REQ       in   [NREQ] level request per requester, held while bus wanted
//   HLDA      in   hold acknowledge from the 8088
//   HOLD      out  hold request to the 8088
//   GNT       out  [NREQ] one-hot grant, at most one bit high
//   OWNER     out  [$clog2(NREQ)] index of the current or last grantee
//   TIMEOUT   out  one-cycle pulse, tenure ended by the cycle limit
//   HLDA_ERR  out  one-cycle pulse, HLDA dropped while a grant was active
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module dma_hold_arbiter #(
  parameter int NREQ            = 4,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NREQ-1:0]         REQ,
  input  logic                    HLDA,
  output logic                    HOLD,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    TIMEOUT,
  output logic                    HLDA_ERR
);

  localparam int OW  = $clog2(NREQ);
  localparam int OW1 = OW + 1;
  localparam int CW  = $clog2(MAX_HOLD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD_REQ = 2'd1;
  localparam logic [1:0] ST_GRANT    = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [CW-1:0]   CNT_MAX   = CW'(MAX_HOLD_CYCLES);
  localparam logic [OW-1:0]   LAST_RST  = OW'(NREQ - 1);
  localparam logic [OW:0]     NREQ_W    = OW1'(NREQ);
  localparam logic [NREQ-1:0] GNT_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic            r_hold;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;
  logic            r_hlda_err;

  // Next-state values
  logic [1:0]      w_state_nxt;
  logic            w_hold_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [OW-1:0]   w_owner_nxt;
  logic [OW-1:0]   w_last_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_timeout_nxt;
  logic            w_hlda_err_nxt;

  // Round-robin search result
  logic [OW-1:0]   w_winner;
  logic            w_found;
  logic            w_owner_req;

  // ---------------------------------------------------------------------------
  // Round-robin winner: the first requester found searching last_owner+1,
  // last_owner+2, ... modulo NREQ. The loop walks from the farthest candidate
  // to the nearest so that the nearest requesting candidate is written last
  // and wins, which avoids a separate "already found" chain.
  // ---------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [OW:0] w_sum;
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = {1'b0, r_last_owner} + OW1'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      if (REQ[w_sum[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[OW-1:0];
      end
    end
  end

  assign w_owner_req = REQ[r_owner];

  // Tenure counter saturates at the limit rather than wrapping.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default here, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_gnt_nxt      = r_gnt;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last_owner;
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = 1'b0;
    w_hlda_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_hold_nxt = 1'b0;
        w_gnt_nxt  = '0;
        if (|REQ) begin
          w_state_nxt = ST_HOLD_REQ;
          w_hold_nxt  = 1'b1;
        end
      end

      ST_HOLD_REQ: begin
        // HOLD is kept until the CPU acknowledges; requests are only looked
        // at on the acknowledge edge.
        if (HLDA) begin
          if (w_found) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = GNT_ONE << w_winner;
            w_owner_nxt = w_winner;
            w_cnt_nxt   = '0;
          end else begin
            // Everyone withdrew while we waited: hand the bus straight back.
            w_state_nxt = ST_RELEASE;
            w_hold_nxt  = 1'b0;
          end
        end
      end

      ST_GRANT: begin
        // r_cnt counts grant cycles already completed, so w_cnt_inc is the
        // count including the cycle ending at this edge.
        w_cnt_nxt = w_cnt_inc;
        if (!HLDA || !w_owner_req || (w_cnt_inc == CNT_MAX)) begin
          w_state_nxt = ST_RELEASE;
          w_hold_nxt  = 1'b0;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_owner;
          // HLDA loss outranks the other two tenure-end causes, and a normal
          // release outranks the timeout, so the two pulses are exclusive.
          if (!HLDA) begin
            w_hlda_err_nxt = 1'b1;
          end else if (w_owner_req) begin
            w_timeout_nxt = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        w_hold_nxt = 1'b0;
        w_gnt_nxt  = '0;
        if (!HLDA) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = 1'b0;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_hold       <= 1'b0;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= LAST_RST;  // requester 0 wins the first arbitration
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_hlda_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_gnt        <= w_gnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
      r_hlda_err   <= w_hlda_err_nxt;
    end
  end

  assign HOLD     = r_hold;
  assign GNT      = r_gnt;
  assign OWNER    = r_owner;
  assign TIMEOUT  = r_timeout;
  assign HLDA_ERR = r_hlda_err;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (!RESET_N)
    $onehot0(r_gnt));
  a_gnt_needs_hold : assert property (@(posedge CLK) disable iff (!RESET_N)
    (r_gnt != '0) |-> (r_hold && (r_state == ST_GRANT)));
  a_pulses_exclusive : assert property (@(posedge CLK) disable iff (!RESET_N)
    !(r_timeout && r_hlda_err));

endmodule

// File: tb/tb_dma_hold_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dma_hold_arbiter
//
// Directed bench for dma_hold_arbiter (NREQ=4, MAX_HOLD_CYCLES=8). A simple
// 8088 responder returns HLDA a programmable number of cycles after HOLD and
// drops it one cycle after HOLD falls. A behavioural model of the bus-lending
// rules predicts every output each cycle; directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_dma_hold_arbiter;

  localparam int NREQ = 4;
  localparam int MAXH = 8;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [NREQ-1:0] REQ;
  logic            HLDA = 1'b0;
  logic            HOLD;
  logic [NREQ-1:0] GNT;
  logic [1:0]      OWNER;
  logic            TIMEOUT;
  logic            HLDA_ERR;

  int n_checks = 0;
  int n_errors = 0;

  // CPU responder controls
  int ack_delay = 3;
  int cpu_mode  = 0;   // 0: well-behaved CPU, 1: HLDA forced low
  int ack_cnt   = 0;

  dma_hold_arbiter #(
    .NREQ            (NREQ),
    .MAX_HOLD_CYCLES (MAXH)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .REQ      (REQ),
    .HLDA     (HLDA),
    .HOLD     (HOLD),
    .GNT      (GNT),
    .OWNER    (OWNER),
    .TIMEOUT  (TIMEOUT),
    .HLDA_ERR (HLDA_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // 8088 responder: acts 2 time units after each posedge so its HLDA level is
  // stable well before the next sampling edge.
  // ---------------------------------------------------------------------------
  always @(posedge CLK) begin
    #2;
    if (cpu_mode != 0) begin
      HLDA    = 1'b0;
      ack_cnt = 0;
    end else if (HOLD && !HLDA) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) HLDA = 1'b1;
    end else if (!HOLD) begin
      HLDA    = 1'b0;
      ack_cnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: who holds the bus, and why a tenure ends.
  //   m_grantee  -1 when no requester owns the bus, else its index
  //   m_hold     HOLD wanted from the CPU
  //   m_drain    bus handed back, waiting for the CPU to drop HLDA
  //   m_len      grant cycles completed in the current tenure
  // q_order / q_len log each tenure's owner and length.
  // ---------------------------------------------------------------------------
  int m_grantee, m_last, m_owner, m_len, m_pick, m_idx;
  bit m_hold, m_drain, m_to, m_err;
  int q_order[$];
  int q_len[$];

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_grantee = -1;
      m_last    = NREQ - 1;
      m_owner   = 0;
      m_len     = 0;
      m_hold    = 0;
      m_drain   = 0;
      m_to      = 0;
      m_err     = 0;
    end else begin
      m_to  = 0;
      m_err = 0;
      if (m_grantee >= 0) begin
        m_len++;
        if (!HLDA || !REQ[m_grantee] || m_len >= MAXH) begin
          if (!HLDA)                m_err = 1;
          else if (REQ[m_grantee])  m_to  = 1;
          q_len.push_back(m_len);
          m_last    = m_grantee;
          m_grantee = -1;
          m_hold    = 0;
          m_drain   = 1;
        end
      end else if (m_drain) begin
        if (!HLDA) m_drain = 0;
      end else if (m_hold) begin
        if (HLDA) begin
          if (REQ != '0) begin
            m_pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
              m_idx = (m_last + k) % NREQ;
              if (m_pick < 0 && REQ[m_idx]) m_pick = m_idx;
            end
            m_grantee = m_pick;
            m_owner   = m_pick;
            m_len     = 0;
            q_order.push_back(m_pick);
          end else begin
            m_hold  = 0;
            m_drain = 1;
          end
        end
      end else if (REQ != '0) begin
        m_hold = 1;
      end
    end
  end

  // Compare every cycle on the falling edge, while out of reset.
  always @(negedge CLK) begin
    if (RESET_N) begin
      check("m_hold",     {31'b0, HOLD},     {31'b0, m_hold});
      check("m_gnt",      {28'b0, GNT},      (m_grantee >= 0) ? (32'd1 << m_grantee) : 32'd0);
      check("m_owner",    {30'b0, OWNER},    m_owner);
      check("m_timeout",  {31'b0, TIMEOUT},  {31'b0, m_to});
      check("m_hlda_err", {31'b0, HLDA_ERR}, {31'b0, m_err});
      check("inv_onehot0", {31'b0, $onehot0(GNT)}, 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(1);
  endtask

  task automatic wait_gnt(input int budget, input string name);
    int k = 0;
    while (GNT == '0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check(name, {31'b0, (GNT != '0)}, 32'd1);
  endtask

  task automatic wait_gnt_low(input int budget);
    int k = 0;
    while (GNT != '0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int hi;
  bit any_gnt, any_to, any_err;

  initial begin
    RESET_N = 1'b0;
    REQ     = '0;
    tick(2);
    check("rst_hold",     {31'b0, HOLD},     32'd0);
    check("rst_gnt",      {28'b0, GNT},      32'd0);
    check("rst_owner",    {30'b0, OWNER},    32'd0);
    check("rst_timeout",  {31'b0, TIMEOUT},  32'd0);
    check("rst_hlda_err", {31'b0, HLDA_ERR}, 32'd0);
    RESET_N = 1'b1;
    tick(2);

    // --- Single request, HLDA after 3 cycles -------------------------------
    q_order.delete(); q_len.delete();
    REQ = 4'b0001;
    tick(1);
    check("t1_hold_latency", {31'b0, HOLD}, 32'd1);
    check("t1_no_gnt_early", {28'b0, GNT},  32'd0);
    tick(3);
    check("t1_gnt",   {28'b0, GNT},   32'h1);
    check("t1_owner", {30'b0, OWNER}, 32'd0);
    tick(2);
    REQ = '0;
    tick(1);
    check("t1_drop_gnt",  {28'b0, GNT},  32'd0);
    check("t1_drop_hold", {31'b0, HOLD}, 32'd0);
    tick(4);
    check("t1_model_len", q_len.size() > 0 ? q_len[0] : -1, 32'd3);

    // --- Round robin with all four requesting -------------------------------
    do_reset();
    q_order.delete(); q_len.delete();
    REQ = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(20, "t2_gnt_wait");
      check("t2_owner", {30'b0, OWNER}, exp_rr[t]);
      check("t2_gnt",   {28'b0, GNT},   32'd1 << exp_rr[t]);
      tick(4);
      REQ[exp_rr[t]] = 1'b0;
      tick(1);
      check("t2_gap_hold", {31'b0, HOLD}, 32'd0);
      check("t2_gap_gnt",  {28'b0, GNT},  32'd0);
      REQ[exp_rr[t]] = 1'b1;
    end
    check("t2_model_count", q_order.size(), 32'd5);
    for (int t = 0; t < 5 && t < q_order.size(); t++) begin
      check("t2_model_order", q_order[t], exp_rr[t]);
      check("t2_model_len",   q_len[t],   32'd5);
    end
    REQ = '0;
    tick(6);

    // --- Timeout -------------------------------------------------------------
    do_reset();
    q_order.delete(); q_len.delete();
    REQ = 4'b0100;
    wait_gnt(20, "t3_gnt_wait");
    check("t3_gnt", {28'b0, GNT}, 32'h4);
    hi = 1;
    for (int g = 0; g < 20 && GNT != '0; g++) begin
      tick(1);
      if (GNT != '0) hi++;
    end
    check("t3_gnt_cycles",    hi,                32'd8);
    check("t3_timeout_pulse", {31'b0, TIMEOUT},  32'd1);
    check("t3_hold_off",      {31'b0, HOLD},     32'd0);
    check("t3_err_quiet",     {31'b0, HLDA_ERR}, 32'd0);
    tick(1);
    check("t3_timeout_once",  {31'b0, TIMEOUT},  32'd0);
    wait_gnt(20, "t3_regrant_wait");
    check("t3_regrant_owner", {30'b0, OWNER}, 32'd2);
    REQ = 4'b1100;
    wait_gnt_low(20);
    wait_gnt(20, "t3_next_wait");
    check("t3_next_owner", {30'b0, OWNER}, 32'd3);
    check("t3_model_len0", q_len.size() > 0 ? q_len[0] : -1, 32'd8);
    check("t3_model_len1", q_len.size() > 1 ? q_len[1] : -1, 32'd8);
    REQ = '0;
    tick(6);

    // --- HLDA loss during a grant -------------------------------------------
    do_reset();
    ack_delay = 3;
    REQ = 4'b0001;
    wait_gnt(20, "t4_gnt_wait");
    tick(2);
    cpu_mode = 1;
    tick(1);
    check("t4_gnt_still", {28'b0, GNT}, 32'h1);
    tick(1);
    check("t4_gnt_drop",  {28'b0, GNT},      32'd0);
    check("t4_hold_drop", {31'b0, HOLD},     32'd0);
    check("t4_err_pulse", {31'b0, HLDA_ERR}, 32'd1);
    check("t4_no_to",     {31'b0, TIMEOUT},  32'd0);
    REQ = '0;
    tick(1);
    check("t4_err_once",  {31'b0, HLDA_ERR}, 32'd0);
    tick(3);
    cpu_mode = 0;
    tick(2);

    // --- Withdrawn request ---------------------------------------------------
    do_reset();
    ack_delay = 4;
    any_gnt = 0; any_to = 0; any_err = 0;
    REQ = 4'b0100;
    tick(1);
    check("t5_hold_up", {31'b0, HOLD}, 32'd1);
    REQ = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t5_hold_wait", {31'b0, HOLD}, 32'd1);
      any_gnt |= (GNT != '0); any_to |= TIMEOUT; any_err |= HLDA_ERR;
    end
    tick(1);
    check("t5_hold_drop", {31'b0, HOLD}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      any_gnt |= (GNT != '0); any_to |= TIMEOUT; any_err |= HLDA_ERR;
      tick(1);
    end
    check("t5_never_gnt", {31'b0, any_gnt}, 32'd0);
    check("t5_never_to",  {31'b0, any_to},  32'd0);
    check("t5_never_err", {31'b0, any_err}, 32'd0);
    ack_delay = 3;

    // --- Asynchronous reset mid-grant ---------------------------------------
    do_reset();
    REQ = 4'b0010;
    wait_gnt(20, "t6_gnt_wait");
    check("t6_gnt",   {28'b0, GNT},   32'h2);
    check("t6_owner", {30'b0, OWNER}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_async_hold",     {31'b0, HOLD},     32'd0);
    check("t6_async_gnt",      {28'b0, GNT},      32'd0);
    check("t6_async_owner",    {30'b0, OWNER},    32'd0);
    check("t6_async_timeout",  {31'b0, TIMEOUT},  32'd0);
    check("t6_async_hlda_err", {31'b0, HLDA_ERR}, 32'd0);
    REQ = 4'b1010;
    tick(2);
    RESET_N = 1'b1;
    wait_gnt(20, "t6_regrant_wait");
    check("t6_first_owner", {30'b0, OWNER}, 32'd1);
    check("t6_first_gnt",   {28'b0, GNT},   32'h2);
    REQ = '0;
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
